control_fsm: RTL

Multicycle control unit: sequences each instruction through fetch, decode, execute, memory and write-back phases, generating datapath and memory-handshake controls per phase. Replaces the single-cycle combinational decoder in the multicycle datapath. Adds B-type (BEQ/BNE) and JAL support, waited instruction/data memory handshakes, a wait watchdog, and a sticky trap on illegal opcodes or memory timeout.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/wait_timer.sv | 36 +++
 rtl/control_fsm.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: state enum, opcode constants, wbsel/pcsrc encodings, opcode legality check.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;

  // Only BEQ/BNE are implemented among the B-type funct3 values.
  function automatic logic op_legal(input logic [6:0] op, input logic [2:0] f3,
                                    input logic br_en, input logic jal_en);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_I, OP_R, OP_S, OP_L: ok = 1'b1;
      OP_B:                   ok = br_en && (f3 == 3'b000 || f3 == 3'b001);
      OP_JAL:                 ok = jal_en;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait watchdog: counts consecutive not-ready cycles, flags expiry on the last allowed one.
// Latency: expired is combinational from the current count and enable.
// Backpressure: none; clear has priority, count saturates at TIMEOUT_CYCLES.
// Ports: clk, rst_n (async low), clear, enable (waiting this cycle), expired.
module wait_timer
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MAX_CNT) begin
      count <= count + CW'(1);
    end
  end

  // Already waited TIMEOUT_CYCLES-1 cycles and still not ready: this one would reach the limit.
  assign expired = enable && (count >= LAST_CNT);

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with sticky illegal/timeout trap.
// Latency: FETCH-to-FETCH 3 (B), 4 (R/I/S/JAL), 5 (L) cycles plus one per memory wait cycle.
// Backpressure: stalls in FETCH/MEM while imem/dmem ready is low; traps after TIMEOUT_CYCLES.
// Ports: clk_i, rst_ni, opcode_i/funct3_i/zero_i, imem/dmem ready in; fetch/memory/datapath
//        controls, sticky illegal_o/timeout_o and state_o out.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_BRANCH = 1'b1,
  parameter bit SUPPORT_JAL    = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  output logic       imem_req_o,
  output logic       ir_write_o,
  output logic       dmem_req_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       regwrite_o,
  output logic       alusrc_o,
  output logic [1:0] wbsel_o,
  output logic       pc_write_o,
  output logic [1:0] pcsrc_o,
  output logic       illegal_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  state_t     state;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       illegal_q;
  logic       timeout_q;
  logic       waiting;
  logic       expired;
  logic       taken;

  // A wait cycle is any FETCH/MEM cycle without ready; any other cycle restarts the count,
  // so the counter is always zero on entry to FETCH or MEM.
  assign waiting = (state == ST_FETCH && !imem_ready_i) ||
                   (state == ST_MEM   && !dmem_ready_i);

  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (!waiting),
    .enable (waiting),
    .expired(expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      f3_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ready_i) begin
            state <= ST_DECODE;
          end else if (expired) begin
            state     <= ST_TRAP;
            timeout_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          op_q <= opcode_i;
          f3_q <= funct3_i;
          if (op_legal(opcode_i, funct3_i, SUPPORT_BRANCH, SUPPORT_JAL)) begin
            state <= ST_EXEC;
          end else begin
            state     <= ST_TRAP;
            illegal_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_B)                       state <= ST_FETCH;
          else if (op_q == OP_S || op_q == OP_L)  state <= ST_MEM;
          else                                    state <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready_i) begin
            state <= (op_q == OP_L) ? ST_WB : ST_FETCH;
          end else if (expired) begin
            state     <= ST_TRAP;
            timeout_q <= 1'b1;
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only BEQ (000) and BNE (001) reach EXEC as branches; BNE inverts the zero flag.
  assign taken = (f3_q == 3'b001) ? !zero_i : zero_i;

  always_comb begin
    imem_req_o = 1'b0;
    ir_write_o = 1'b0;
    dmem_req_o = 1'b0;
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    regwrite_o = 1'b0;
    alusrc_o   = 1'b0;
    wbsel_o    = WB_ALU;
    pc_write_o = 1'b0;
    pcsrc_o    = PC_PLUS4;
    case (state)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        ir_write_o = imem_ready_i;
      end
      ST_EXEC: begin
        alusrc_o = (op_q == OP_I || op_q == OP_S || op_q == OP_L);
        if (op_q == OP_B) begin
          pc_write_o = 1'b1;
          pcsrc_o    = taken ? PC_BRANCH : PC_PLUS4;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        memread_o  = (op_q == OP_L);
        memwrite_o = (op_q == OP_S);
        if (dmem_ready_i && op_q == OP_S) begin
          pc_write_o = 1'b1;
          pcsrc_o    = PC_PLUS4;
        end
      end
      ST_WB: begin
        regwrite_o = 1'b1;
        pc_write_o = 1'b1;
        if (op_q == OP_L) begin
          wbsel_o = WB_MEM;
        end else if (op_q == OP_JAL) begin
          wbsel_o = WB_PC4;
          pcsrc_o = PC_JAL;
        end
      end
      default: ;
    endcase
  end

  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;
  assign state_o   = state;

endmodule
